// File: rtl/morse_decodificador_pkg.sv
// Shared Morse definitions for the digit decoder (and the digit encoder bench).
//   - FSM state encoding: IDLE, MARK, SPACE
//   - Symbol values: DOT = 1, DASH = 0
//   - PATTERNS: the 10 legal 5-symbol codes, indexed by digit. s1 (first
//     symbol on the line) is bit 4 of each entry.
//   - pattern_of(): digit -> code lookup helper
package morse_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARK  = 2'd1;
  localparam logic [1:0] SPACE = 2'd2;

  localparam logic DOT  = 1'b1;
  localparam logic DASH = 1'b0;

  // Entry [d] is the code for digit d.
  localparam logic [9:0][4:0] PATTERNS = {
    5'b00001,  // 9
    5'b00011,  // 8
    5'b00111,  // 7
    5'b01111,  // 6
    5'b11111,  // 5
    5'b11110,  // 4
    5'b11100,  // 3
    5'b11000,  // 2
    5'b10000,  // 1
    5'b00000   // 0
  };

  function automatic logic [4:0] pattern_of(input logic [3:0] d);
    return (d < 4'd10) ? PATTERNS[d] : 5'b00000;
  endfunction

endpackage

// File: rtl/morse_decodificador_if.sv
// Keyed-line / decoded-digit bundle of the Morse decoder.
//   key   : keyed line, 1 = mark
//   digit : last decoded digit
//   valid : one-cycle pulse, digit updated
//   error : one-cycle pulse, character was not a legal digit
//   busy  : character in progress
// master drives the key line and observes the results; slave is the decoder.
interface morse_decodificador_if;
  logic       key;
  logic [3:0] digit;
  logic       valid;
  logic       error;
  logic       busy;

  modport master (output key, input digit, valid, error, busy);
  modport slave  (input key, output digit, valid, error, busy);
endinterface

// File: rtl/morse_decodificador_tabela.sv
// morse_tabela: combinational Morse code -> digit lookup.
//   pattern : 5-bit code, s1 in bit 4
//   digit   : decoded digit (0 when no entry matches)
//   hit     : pattern is one of the 10 legal codes
module morse_tabela
  import morse_pkg::*;
(
  input  logic [4:0] pattern,
  output logic [3:0] digit,
  output logic       hit
);

  always_comb begin
    digit = '0;
    hit   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (PATTERNS[i] == pattern) begin
        digit = 4'(i);
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_decodificador.sv
// morse_decodificador: times presses/gaps on a keyed Morse line, classifies
// presses as dot (< DASH_MIN cycles) or dash, collects up to 5 symbols and
// decodes the character to a digit once GAP_CHAR consecutive low samples
// have been seen.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus.key    : keyed line (input)
//   bus.digit  : last decoded digit, held
//   bus.valid  : one-cycle pulse on a legal character
//   bus.error  : one-cycle pulse on a short, overlong or illegal character
//   bus.busy   : registered, high while state != IDLE
// Optional macro MORSE_DEC_SYNC_EN: inserts a 2-flop synchronizer on key
// (adds 2 cycles of latency, duration rules unchanged).
module morse_decodificador
  import morse_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DASH_MIN = 3,
  parameter int GAP_CHAR = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  morse_decodificador_if.slave    bus
);

  logic             key_s;
  logic [1:0]       state, next_state;
  logic [CNT_W-1:0] len, gap;
  logic [4:0]       pat;
  logic [2:0]       cnt;
  logic             ovf;
  logic             done;
  logic             sym;
  logic             gap_end;
  logic [3:0]       tab_digit;
  logic             tab_hit;
  logic             valid_d, error_d;

`ifdef MORSE_DEC_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], bus.key};
  end
  assign key_s = sync_q[1];
`else
  assign key_s = bus.key;
`endif

  assign sym = (len >= CNT_W'(DASH_MIN)) ? DASH : DOT;
  // gap already holds the lows seen so far; this sample is one more.
  assign gap_end = (gap >= CNT_W'(GAP_CHAR - 1));

  morse_tabela u_tabela (
    .pattern (pat),
    .digit   (tab_digit),
    .hit     (tab_hit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (key_s) next_state = MARK;
      MARK:    if (!key_s) next_state = SPACE;
      SPACE: begin
        if (key_s)        next_state = MARK;
        else if (gap_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Duration counters, symbol collection and end-of-character flag
  always_ff @(posedge clk) begin
    if (reset) begin
      len  <= '0;
      gap  <= '0;
      pat  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      // Evaluation happens one cycle after the character closes so the
      // result sees the final symbol state registered.
      done <= (state == SPACE) && !key_s && gap_end;
      case (state)
        IDLE: begin
          if (key_s) begin
            len <= CNT_W'(1);
            cnt <= '0;
            ovf <= 1'b0;
            pat <= '0;
          end
        end
        MARK: begin
          if (key_s) begin
            if (len != '1) len <= len + 1'b1;
          end else begin
            if (cnt < 3'd5) begin
              pat[3'd4 - cnt] <= sym;
              cnt             <= cnt + 3'd1;
            end else begin
              ovf <= 1'b1;
            end
            gap <= CNT_W'(1);
          end
        end
        SPACE: begin
          if (key_s)          len <= CNT_W'(1);
          else if (gap != '1) gap <= gap + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    valid_d = done && (cnt == 3'd5) && !ovf && tab_hit;
    error_d = done && !valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.digit <= '0;
      bus.valid <= 1'b0;
      bus.error <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      bus.valid <= valid_d;
      bus.error <= error_d;
      bus.busy  <= (next_state != IDLE);
      if (valid_d) bus.digit <= tab_digit;
    end
  end

endmodule

// File: tb/tb_morse_decodificador.sv
// Bench for morse_decodificador: directed scenarios plus randomized
// characters, checked against a symbol-level reference model.
// Build with +define+MORSE_DEC_SYNC_EN to exercise the synchronized key path.
module tb_morse_decodificador;

`ifdef MORSE_DEC_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // Negedges from the key falling after the last press to the pulse.
  localparam int LAT = 6 + SYNC;

  logic clk = 1'b0;
  logic reset;
  morse_decodificador_if bus ();

  morse_decodificador dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_digit = 0;
  int plen [8];
  int glen [8];
  // Codes for digits 0..9, s1 as the most significant of the 5 bits.
  int code_tab [10] = '{0, 16, 24, 28, 30, 31, 15, 7, 3, 1};

  task automatic chk(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Reference: press >= 3 cycles is a dash (0), else a dot (1); a character
  // is legal only with exactly 5 symbols forming a table entry.
  task automatic model(input int n, output bit ok, output int dig);
    int code;
    ok = 1'b0;
    dig = 0;
    code = 0;
    if (n == 5) begin
      for (int i = 0; i < 5; i++) code = code * 2 + ((plen[i] >= 3) ? 0 : 1);
      for (int d = 0; d < 10; d++)
        if (code_tab[d] == code) begin
          ok = 1'b1;
          dig = d;
        end
    end
  endtask

  // Plays n presses (plen/glen) and a tail of low cycles, checking outputs
  // on every falling edge.
  task automatic send_char(input int n, input int tail, input string tag);
    bit ok;
    int dig;
    model(n, ok, dig);
    for (int i = 0; i < n; i++) begin
      bus.key = 1'b1;
      for (int c = 0; c < plen[i]; c++) begin
        @(negedge clk);
        chk({tag, " valid-press"}, bus.valid, 0);
        chk({tag, " error-press"}, bus.error, 0);
      end
      bus.key = 1'b0;
      if (i < n - 1) begin
        for (int c = 0; c < glen[i]; c++) begin
          @(negedge clk);
          chk({tag, " valid-gap"}, bus.valid, 0);
          chk({tag, " error-gap"}, bus.error, 0);
        end
      end
    end
    for (int j = 1; j <= tail; j++) begin
      @(negedge clk);
      if (j == LAT && ok) exp_digit = dig;
      chk({tag, " valid"}, bus.valid, (j == LAT && ok) ? 1 : 0);
      chk({tag, " error"}, bus.error, (j == LAT && !ok) ? 1 : 0);
      chk({tag, " busy"}, bus.busy, (j < 5 + SYNC) ? 1 : 0);
      chk({tag, " digit"}, bus.digit, exp_digit);
    end
  endtask

  task automatic set_all(input int p0, p1, p2, p3, p4, input int g);
    plen[0] = p0; plen[1] = p1; plen[2] = p2; plen[3] = p3; plen[4] = p4;
    for (int i = 0; i < 8; i++) glen[i] = g;
  endtask

  initial begin
    bus.key = 1'b0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst digit", bus.digit, 0);
    chk("rst valid", bus.valid, 0);
    chk("rst error", bus.error, 0);
    chk("rst busy", bus.busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // 4,4,1,1,1 with 2-cycle gaps -> 00111 -> 7
    set_all(4, 4, 1, 1, 1, 2);
    send_char(5, 10, "seven");
    // five 1-cycle dots, 1-cycle gaps -> 5
    set_all(1, 1, 1, 1, 1, 1);
    send_char(5, 10, "five");
    // five 3-cycle dashes -> 0
    set_all(3, 3, 3, 3, 3, 1);
    send_char(5, 10, "zero");
    // 2-cycle presses are dots -> 5; dash then 2-cycle dots -> 6
    set_all(2, 2, 2, 2, 2, 1);
    send_char(5, 10, "dot2");
    set_all(3, 2, 2, 2, 2, 1);
    send_char(5, 10, "six");
    // too few symbols, overflow, illegal pattern 10101
    set_all(1, 1, 1, 1, 1, 2);
    send_char(3, 10, "short");
    plen[5] = 1;
    send_char(6, 10, "ovf");
    set_all(1, 4, 1, 4, 1, 2);
    send_char(5, 10, "illegal");
    // 4-cycle gaps keep the character together -> 5
    set_all(1, 1, 1, 1, 1, 4);
    send_char(5, 10, "gap4");

    // Reset during the third press
    set_all(1, 1, 1, 1, 1, 2);
    bus.key = 1'b1;
    @(negedge clk);
    bus.key = 1'b0;
    repeat (2) @(negedge clk);
    bus.key = 1'b1;
    @(negedge clk);
    bus.key = 1'b0;
    repeat (2) @(negedge clk);
    bus.key = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.key = 1'b0;
    exp_digit = 0;
    chk("midrst digit", bus.digit, 0);
    chk("midrst valid", bus.valid, 0);
    chk("midrst error", bus.error, 0);
    chk("midrst busy", bus.busy, 0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("midrst no valid", bus.valid, 0);
      chk("midrst no error", bus.error, 0);
    end
    set_all(4, 4, 1, 1, 1, 2);
    send_char(5, 10, "after-rst");

    // Randomized characters
    for (int t = 0; t < 40; t++) begin
      int n;
      int mode;
      mode = $urandom_range(0, 9);
      for (int i = 0; i < 8; i++) glen[i] = $urandom_range(1, 4);
      if (mode < 6) begin
        int d;
        n = 5;
        d = $urandom_range(0, 9);
        for (int i = 0; i < 5; i++)
          plen[i] = ((code_tab[d] >> (4 - i)) & 1) ? $urandom_range(1, 2)
                                                   : $urandom_range(3, 6);
      end else begin
        n = (mode == 9) ? $urandom_range(1, 7) : 5;
        for (int i = 0; i < 8; i++) plen[i] = $urandom_range(1, 5);
      end
      send_char(n, $urandom_range(10, 13), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
